// File: rtl/if_id_decode_queue_if.sv
// Handshake buses for the IF/ID queue: the fetch-side offer and the decode-side head entry.
// The master modport is the side that produces the data; the slave modport consumes it.
interface if_id_fetch_if #(
  parameter int PC_W = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc4;

  modport master (output if_valid, if_instr, if_pc4, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc4, output if_ready);
endinterface

interface if_id_decode_if #(
  parameter int PC_W = 32
);
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [PC_W-1:0] id_pc4;
  logic            id_ext_op;
  logic            id_imm_ch;
  logic            id_shamt_ctr;
  logic            id_shift_ctr;
  logic            id_jump;
  logic            id_jump_reg;
  logic [PC_W-1:0] id_jtarget;

  modport master (
    output id_valid, id_instr, id_pc4, id_ext_op, id_imm_ch, id_shamt_ctr,
           id_shift_ctr, id_jump, id_jump_reg, id_jtarget,
    input  id_ready
  );
  modport slave (
    input  id_valid, id_instr, id_pc4, id_ext_op, id_imm_ch, id_shamt_ctr,
           id_shift_ctr, id_jump, id_jump_reg, id_jtarget,
    output id_ready
  );
endinterface

// File: rtl/if_id_decode_queue.sv
// IF/ID boundary queue: DEPTH-entry FIFO that pre-decodes MIPS control bits at enqueue,
// with flush, jump-target generation and a saturating decode-stall counter.
module if_id_decode_queue #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  if_id_fetch_if.slave     i_fetch,
  if_id_decode_if.master   o_decode,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Control bits packed as {ext_op, imm_ch, shamt, shift, jump, jump_reg}
  logic [31:0]     r_instr [DEPTH];
  logic [PC_W-1:0] r_pc4   [DEPTH];
  logic [5:0]      r_ctl   [DEPTH];

  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic            w_ext_op;
  logic            w_imm_ch;
  logic            w_shamt;
  logic            w_shift;
  logic            w_jump;
  logic            w_jump_reg;
  logic [5:0]      w_ctl;
  logic            w_if_ready;
  logic            w_valid;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_head_instr;
  logic [PC_W-1:0] w_head_pc4;
  logic [5:0]      w_head_ctl;
  logic [PC_W-1:0] w_jtarget;

  assign w_op    = i_fetch.if_instr[31:26];
  assign w_funct = i_fetch.if_instr[5:0];

  assign w_ext_op   = w_op inside {6'h08, 6'h09, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0A,
                                   6'h0B, 6'h01, 6'h07, 6'h06, 6'h20, 6'h24, 6'h28};
  assign w_imm_ch   = w_ext_op | (w_op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F});
  assign w_shamt    = (w_op == 6'h00) & (w_funct inside {6'h00, 6'h02, 6'h03});
  assign w_shift    = (w_op == 6'h00) &
                      (w_funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
  assign w_jump     = w_op inside {6'h02, 6'h03};
  assign w_jump_reg = (w_op == 6'h00) & (w_funct inside {6'h08, 6'h09});
  assign w_ctl      = {w_ext_op, w_imm_ch, w_shamt, w_shift, w_jump, w_jump_reg};

  // Ready depends only on registered occupancy, so no id_ready -> if_ready path exists
  assign w_if_ready = (r_count < FULL_CNT);
  assign w_valid    = (r_count != '0);
  assign w_push     = i_fetch.if_valid & w_if_ready;
  assign w_pop      = w_valid & o_decode.id_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: id_* are gated by occupancy
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_instr[r_wr_ptr] <= i_fetch.if_instr;
      r_pc4[r_wr_ptr]   <= i_fetch.if_pc4;
      r_ctl[r_wr_ptr]   <= w_ctl;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_valid && !o_decode.id_ready && !i_flush && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign w_head_instr = w_valid ? r_instr[r_rd_ptr] : '0;
  assign w_head_pc4   = w_valid ? r_pc4[r_rd_ptr]   : '0;
  assign w_head_ctl   = w_valid ? r_ctl[r_rd_ptr]   : '0;

  generate
    if (PC_W > 28) begin : g_jt_region
      assign w_jtarget = {w_head_pc4[PC_W-1:28], w_head_instr[25:0], 2'b00};
    end else begin : g_jt_plain
      assign w_jtarget = {w_head_instr[25:0], 2'b00};
    end
  endgenerate

  assign i_fetch.if_ready      = w_if_ready;
  assign o_decode.id_valid     = w_valid;
  assign o_decode.id_instr     = w_head_instr;
  assign o_decode.id_pc4       = w_head_pc4;
  assign o_decode.id_ext_op    = w_head_ctl[5];
  assign o_decode.id_imm_ch    = w_head_ctl[4];
  assign o_decode.id_shamt_ctr = w_head_ctl[3];
  assign o_decode.id_shift_ctr = w_head_ctl[2];
  assign o_decode.id_jump      = w_head_ctl[1];
  assign o_decode.id_jump_reg  = w_head_ctl[0];
  assign o_decode.id_jtarget   = w_jtarget;
  assign o_stall_cnt           = r_stall_cnt;

endmodule

// File: tb/tb_if_id_decode_queue.sv
// Bench for if_id_decode_queue: directed scenarios plus random traffic, all compared
// cycle by cycle against a queue-based reference model.
module tb_if_id_decode_queue;

  localparam int PC_W  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 5;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc4;
  } entry_t;

  logic clk = 1'b0;
  logic rstN;
  logic flush;
  logic [CNT_W-1:0] stallCnt;

  if_id_fetch_if  #(.PC_W(PC_W)) fetchBus ();
  if_id_decode_if #(.PC_W(PC_W)) decodeBus ();

  if_id_decode_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_flush     (flush),
    .i_fetch     (fetchBus.slave),
    .o_decode    (decodeBus.master),
    .o_stall_cnt (stallCnt)
  );

  always #5 clk = ~clk;

  entry_t modelQ[$];
  int     modelStall = 0;
  int     checkCount = 0;
  int     passCount  = 0;
  int     failCount  = 0;
  bit     lastTaken  = 1'b1;
  string  phase      = "reset";

  // Control bits {ext_op, imm_ch, shamt, shift, jump, jump_reg} straight from the opcode tables
  function automatic logic [5:0] refDecode(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic ext, imm, sa, sh, j, jr;
    op  = w[31:26];
    fn  = w[5:0];
    ext = op inside {6'h08, 6'h09, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0A,
                     6'h0B, 6'h01, 6'h07, 6'h06, 6'h20, 6'h24, 6'h28};
    imm = ext || (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F});
    sa  = (op == 6'h00) && (fn inside {6'h00, 6'h02, 6'h03});
    sh  = (op == 6'h00) && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
    j   = op inside {6'h02, 6'h03};
    jr  = (op == 6'h00) && (fn inside {6'h08, 6'h09});
    return {ext, imm, sa, sh, j, jr};
  endfunction

  function automatic logic [31:0] randWord();
    logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h0F, 6'h04};
    logic [5:0] fns [8]  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09, 6'h20};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 7) w[31:26] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 9) < 7) w[5:0]   = fns[$urandom_range(0, 7)];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    logic [5:0]      ctl;
    logic [31:0]     ins;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] jt;
    bit              v;
    v   = (modelQ.size() != 0);
    ins = v ? modelQ[0].instr : '0;
    pc  = v ? modelQ[0].pc4   : '0;
    ctl = v ? refDecode(ins)  : '0;
    jt  = v ? ((pc & 32'hF000_0000) | {4'h0, ins[25:0], 2'b00}) : '0;
    checkOutput({phase, ".id_valid"}, decodeBus.id_valid, v);
    checkOutput({phase, ".if_ready"}, fetchBus.if_ready, modelQ.size() < DEPTH);
    checkOutput({phase, ".id_instr"}, decodeBus.id_instr, ins);
    checkOutput({phase, ".id_pc4"}, decodeBus.id_pc4, pc);
    checkOutput({phase, ".ctl"}, {decodeBus.id_ext_op, decodeBus.id_imm_ch, decodeBus.id_shamt_ctr,
                                  decodeBus.id_shift_ctr, decodeBus.id_jump, decodeBus.id_jump_reg}, ctl);
    checkOutput({phase, ".jtarget"}, decodeBus.id_jtarget, jt);
    checkOutput({phase, ".stall_cnt"}, stallCnt, modelStall);
  endtask

  task automatic applyStimulus(input bit valid, input logic [31:0] instr,
                               input logic [PC_W-1:0] pc4, input bit ready, input bit fl);
    fetchBus.if_valid  = valid;
    fetchBus.if_instr  = instr;
    fetchBus.if_pc4    = pc4;
    decodeBus.id_ready = ready;
    flush              = fl;
  endtask

  // One clock: predict from the pre-edge inputs, advance the model, then compare #1 later
  task automatic tick();
    bit     push, pop, stallInc;
    entry_t e;
    push     = fetchBus.if_valid && (modelQ.size() < DEPTH);
    pop      = (modelQ.size() != 0) && decodeBus.id_ready;
    stallInc = (modelQ.size() != 0) && !decodeBus.id_ready && !flush;
    e        = '{instr: fetchBus.if_instr, pc4: fetchBus.if_pc4};
    @(posedge clk);
    if (flush) begin
      modelQ.delete();
    end else begin
      if (pop)  void'(modelQ.pop_front());
      if (push) modelQ.push_back(e);
    end
    if (stallInc && modelStall < STALL_MAX) modelStall++;
    lastTaken = push || !fetchBus.if_valid;
    #1;
    checkModel();
  endtask

  task automatic runRandom(input int n);
    for (int i = 0; i < n; i++) begin
      if (lastTaken) begin
        fetchBus.if_valid = ($urandom_range(0, 3) != 0);
        fetchBus.if_instr = randWord();
        fetchBus.if_pc4   = $urandom & 32'hFFFF_FFFC;
      end
      decodeBus.id_ready = ($urandom_range(0, 2) != 0);
      flush              = ($urandom_range(0, 24) == 0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    applyStimulus(0, '0, '0, 0, 0);
    #3;
    phase = "reset";
    checkModel();
    checkOutput("reset.if_ready_const", fetchBus.if_ready, 1);
    #9 rstN = 1'b1;

    // Single addi, consumed as soon as it reaches the head
    phase = "addi";
    applyStimulus(1, 32'h2008_0005, 32'h104, 1, 0);
    tick();
    checkOutput("addi.valid", decodeBus.id_valid, 1);
    checkOutput("addi.ext_op", decodeBus.id_ext_op, 1);
    checkOutput("addi.imm_ch", decodeBus.id_imm_ch, 1);
    checkOutput("addi.shift", decodeBus.id_shift_ctr, 0);
    applyStimulus(0, '0, '0, 1, 0);
    tick();
    checkOutput("addi.popped", decodeBus.id_valid, 0);

    phase = "jump";
    applyStimulus(1, 32'h0810_0040, 32'h4000_0008, 1, 0);
    tick();
    checkOutput("jump.id_jump", decodeBus.id_jump, 1);
    checkOutput("jump.jtarget", decodeBus.id_jtarget, 32'h4040_0100);
    applyStimulus(0, '0, '0, 1, 0);
    tick();

    // Three back-to-back words into a two-entry queue with decode stalled
    phase = "full";
    applyStimulus(1, 32'h2129_0001, 32'h200, 0, 0);
    tick();
    applyStimulus(1, 32'h214A_0002, 32'h204, 0, 0);
    tick();
    checkOutput("full.if_ready", fetchBus.if_ready, 0);
    applyStimulus(1, 32'h216B_0003, 32'h208, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("full.stall_cnt", stallCnt, 5);
    decodeBus.id_ready = 1'b1;
    tick();
    checkOutput("full.order_b", decodeBus.id_instr, 32'h214A_0002);
    tick();
    checkOutput("full.order_c", decodeBus.id_instr, 32'h216B_0003);
    applyStimulus(0, '0, '0, 1, 0);
    tick();

    phase = "flush";
    applyStimulus(1, 32'h3C01_1234, 32'h300, 0, 0);
    tick();
    applyStimulus(1, 32'h3421_5678, 32'h304, 0, 0);
    tick();
    applyStimulus(1, 32'hDEAD_BEEF, 32'h308, 0, 1);
    tick();
    checkOutput("flush.valid", decodeBus.id_valid, 0);
    checkOutput("flush.if_ready", fetchBus.if_ready, 1);
    checkOutput("flush.stall_held", stallCnt, 6);
    applyStimulus(0, '0, '0, 1, 0);
    tick();
    tick();
    checkOutput("flush.no_ghost", decodeBus.id_valid, 0);

    // Streaming: one word in and one out per cycle across several pointer wraps
    phase = "stream";
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'h2000_0000 + 32'(i), 32'h1000 + 32'(4 * i), 1, 0);
      tick();
      checkOutput("stream.head", decodeBus.id_instr, 32'h2000_0000 + 32'(i));
      checkOutput("stream.if_ready", fetchBus.if_ready, 1);
    end
    applyStimulus(0, '0, '0, 1, 0);
    tick();

    phase = "sweep";
    applyStimulus(1, 32'h0000_0000, 32'h500, 1, 0);
    tick();
    checkOutput("sweep.sll", {decodeBus.id_shamt_ctr, decodeBus.id_shift_ctr}, 2'b11);
    applyStimulus(1, 32'h0000_0004, 32'h504, 1, 0);
    tick();
    checkOutput("sweep.sllv", {decodeBus.id_shamt_ctr, decodeBus.id_shift_ctr}, 2'b01);
    applyStimulus(1, 32'h0000_F809, 32'h508, 1, 0);
    tick();
    checkOutput("sweep.jalr", decodeBus.id_jump_reg, 1);
    applyStimulus(1, 32'h3508_00FF, 32'h50C, 1, 0);
    tick();
    checkOutput("sweep.ori", {decodeBus.id_ext_op, decodeBus.id_imm_ch}, 2'b01);
    applyStimulus(0, '0, '0, 1, 0);
    tick();

    phase = "random";
    lastTaken = 1'b1;
    runRandom(300);

    // Long stall drives the counter into saturation
    phase = "saturate";
    applyStimulus(1, randWord(), 32'h600, 0, 0);
    for (int i = 0; i < 40; i++) tick();
    checkOutput("saturate.stall_cnt", stallCnt, STALL_MAX);

    // Asynchronous reset with the queue full, away from any clock edge
    phase = "async_reset";
    rstN = 1'b0;
    #1;
    modelQ.delete();
    modelStall = 0;
    checkOutput("async_reset.valid", decodeBus.id_valid, 0);
    checkOutput("async_reset.if_ready", fetchBus.if_ready, 1);
    checkOutput("async_reset.stall_cnt", stallCnt, 0);
    checkOutput("async_reset.instr", decodeBus.id_instr, 0);
    applyStimulus(0, '0, '0, 0, 0);
    #2 rstN = 1'b1;

    phase = "post_reset";
    lastTaken = 1'b1;
    runRandom(40);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
